pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: sequences latch enables and bubble inserts for a
// five-stage pipeline. It handles load-use stalls, taken-branch flushes, I-cache
// misses, D-side waits and the terminal halt.
// Optional build macro PIPELINE_HAZARD_CTRL_PERF_EN adds the stall_cnt and
// flush_cnt performance counters.
module pipeline_hazard_ctrl (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dmemREN_mem,
  input  logic       dmemWEN_mem,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] wsel_ex,
  input  logic       memread_ex,
  input  logic       branch_taken_mem,
  input  logic       halt_wb,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_sRST,
  output logic       idex_sRST,
  output logic       exmem_sRST,
  output logic       memwb_sRST,
  output logic       halted
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;

  logic dreq;
  logic adv;
  logic load_use;
  logic active;

  assign dreq     = dmemREN_mem | dmemWEN_mem;
  assign adv      = ~dreq | dhit;
  assign load_use = memread_ex && (wsel_ex != REG_W'(0)) &&
                    ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  // Enable/bubble decode; DWAIT releases with normal RUN outputs on dhit.
  always_comb begin
    active     = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_sRST  = 1'b0;
    idex_sRST  = 1'b0;
    exmem_sRST = 1'b0;
    memwb_sRST = 1'b0;
    if (nRST) begin
      case (state)
        RUN:     active = adv;
        DWAIT:   active = dhit;
        default: active = 1'b0;
      endcase
    end
    if (active) begin
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (branch_taken_mem) begin
        // Squash the three younger stages and let the PC take the target.
        pc_en      = 1'b1;
        ifid_sRST  = 1'b1;
        idex_sRST  = 1'b1;
        exmem_sRST = 1'b1;
      end else if (load_use) begin
        // Hold IF/ID and the PC, drop one bubble into EX.
        ifid_en   = 1'b0;
        idex_sRST = 1'b1;
      end else begin
        pc_en     = ihit;
        ifid_sRST = ~ihit;
      end
    end
  end

  // State register and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (halt_wb || (state == HALT)) begin
      state  <= HALT;
      halted <= 1'b1;
    end else begin
      case (state)
        RUN:     if (dreq && !dhit) state <= DWAIT;
        DWAIT:   if (dhit) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  // Free-running wrap-around stall and flush counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && !pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken_mem && adv)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus hand sequences
// for DWAIT, HALT and reset corners, checked through an expected-value queue.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dmemREN_mem, dmemWEN_mem;
  logic [4:0] rs_id, rt_id, wsel_ex;
  logic       memread_ex, branch_taken_mem, halt_wb;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST, halted;
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .rs_id(rs_id), .rt_id(rt_id), .wsel_ex(wsel_ex),
    .memread_ex(memread_ex), .branch_taken_mem(branch_taken_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_sRST(ifid_sRST), .idex_sRST(idex_sRST),
    .exmem_sRST(exmem_sRST), .memwb_sRST(memwb_sRST), .halted(halted)
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Output bit order: pc, ifid, idex, exmem, memwb | ifid_s, idex_s, exmem_s, memwb_s | halted
  localparam logic [9:0] E_ZERO = 10'b00000_0000_0;
  localparam logic [9:0] E_IDLE = 10'b11111_0000_0;
  localparam logic [9:0] E_MISS = 10'b01111_1000_0;
  localparam logic [9:0] E_LU   = 10'b00111_0100_0;
  localparam logic [9:0] E_BR   = 10'b11111_1110_0;
  localparam logic [9:0] E_HALT = 10'b00000_0000_1;

  typedef struct {
    logic       ih, dh, rn, wn;
    logic [4:0] rs, rt, ws;
    logic       mr, br, hl;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic in_t mk(logic ih, logic dh, logic rn, logic wn,
                             logic [4:0] rs, logic [4:0] rt, logic [4:0] ws,
                             logic mr, logic br, logic hl);
    in_t r;
    r.ih = ih; r.dh = dh; r.rn = rn; r.wn = wn;
    r.rs = rs; r.rt = rt; r.ws = ws;
    r.mr = mr; r.br = br; r.hl = hl;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST, halted};
  endfunction

  task automatic drive(input in_t v);
    ihit = v.ih; dhit = v.dh; dmemREN_mem = v.rn; dmemWEN_mem = v.wn;
    rs_id = v.rs; rt_id = v.rt; wsel_ex = v.ws;
    memread_ex = v.mr; branch_taken_mem = v.br; halt_wb = v.hl;
  endtask

  task automatic expect_out(input string name, input logic [9:0] exp);
    sb_t e;
    e.name = name; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the live outputs.
  task automatic compare();
    sb_t e;
    logic [9:0] act;
    e = sb_q.pop_front();
    act = outs();
    n_checks++;
    if (act === e.exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
  endtask

  // One cycle: drive after the edge, check mid-cycle, advance past the next edge.
  task automatic step(input string name, input in_t v, input logic [9:0] exp);
    drive(v);
    expect_out(name, exp);
    @(negedge CLK);
    compare();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_now(input string name, input logic [9:0] exp);
    expect_out(name, exp);
    #1;
    compare();
  endtask

  in_t idle, miss, dwr, dwr_hit, none;

  initial begin
    idle    = mk(1, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    miss    = mk(0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    dwr     = mk(1, 0, 1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    dwr_hit = mk(1, 1, 1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    none    = mk(1, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0);

    vecs[0] = '{"idle",        idle,                                        E_IDLE};
    vecs[1] = '{"imiss",       miss,                                        E_MISS};
    vecs[2] = '{"lu_rs",       mk(1, 0, 0, 0, 5'd8, 5'd3, 5'd8, 1, 0, 0),   E_LU};
    vecs[3] = '{"lu_rt",       mk(1, 0, 0, 0, 5'd4, 5'd8, 5'd8, 1, 0, 0),   E_LU};
    vecs[4] = '{"lu_r0",       mk(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0),   E_IDLE};
    vecs[5] = '{"nolu_nomr",   mk(1, 0, 0, 0, 5'd8, 5'd8, 5'd8, 0, 0, 0),   E_IDLE};
    vecs[6] = '{"br_over_lu",  mk(1, 0, 0, 0, 5'd8, 5'd3, 5'd8, 1, 1, 0),   E_BR};
    vecs[7] = '{"br_imiss",    mk(0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 1, 0),   E_BR};
    vecs[8] = '{"store_hit",   mk(1, 1, 0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 0),   E_IDLE};
    vecs[9] = '{"lu_imiss",    mk(0, 0, 0, 0, 5'd8, 5'd3, 5'd8, 1, 0, 0),   E_LU};

    // Reset behaviour and first cycle out of reset.
    nRST = 1'b0;
    drive(idle);
    @(posedge CLK);
    #1;
    check_now("rst_hold", E_ZERO);
    nRST = 1'b1;
    step("post_rst", idle, E_IDLE);

    // Combinational decode table in RUN.
    for (int i = 0; i < 10; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Load miss for three cycles, hit on the fourth, then back in RUN.
    step("dw_1", dwr, E_ZERO);
    step("dw_2", dwr, E_ZERO);
    step("dw_3", dwr, E_ZERO);
    step("dw_hit", dwr_hit, E_IDLE);
    step("dw_back", idle, E_IDLE);

    // DWAIT waits for dhit even if the request drops; release with a branch.
    step("dwb_enter", mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 0), E_ZERO);
    step("dwb_nodreq", idle, E_ZERO);
    step("dwb_hit_br", mk(1, 1, 0, 1, 5'd1, 5'd2, 5'd3, 0, 1, 0), E_BR);
    step("dwb_back", idle, E_IDLE);

    // Reset in the middle of DWAIT leaves nothing behind.
    step("dwr_enter", dwr, E_ZERO);
    step("dwr_hold", dwr, E_ZERO);
    drive(idle);
    nRST = 1'b0;
    check_now("dwr_in_rst", E_ZERO);
    nRST = 1'b1;
    #1;
    step("dwr_after", idle, E_IDLE);

    // Halt: two fetch-miss cycles, halt request, then sticky HALT.
    step("h_pre1", miss, E_MISS);
    step("h_pre2", miss, E_MISS);
    step("h_req", mk(0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1), E_MISS);
    step("h_1", idle, E_HALT);
    step("h_2", idle, E_HALT);
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    n_checks++;
    if (stall_cnt === 32'd3) n_pass++;
    else $display("FAIL stall_cnt_halt: got %0d expected 3", stall_cnt);
    n_checks++;
    if (flush_cnt === 32'd0) n_pass++;
    else $display("FAIL flush_cnt_halt: got %0d expected 0", flush_cnt);
`endif
    step("h_ignore", mk(1, 1, 1, 0, 5'd8, 5'd8, 5'd8, 1, 1, 0), E_HALT);
    step("h_3", none, E_HALT);

    // Reset clears the halt.
    nRST = 1'b0;
    check_now("h_in_rst", E_ZERO);
    nRST = 1'b1;
    #1;
    step("h_after_rst", idle, E_IDLE);

    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d left expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
